// File: rtl/seg_pkg.sv
// +---------------------------------------------------------------------------+
// | seg_pkg : shared constants and types for the seven-segment scan logic    |
// | Revision: 1.0                                                            |
// +---------------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } seg_state_e;

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
// +---------------------------------------------------------------------------+
// | hex7seg : combinational hex nibble to active-low seven-segment decoder   |
// | Revision: 1.0                                                            |
// +---------------------------------------------------------------------------+
`default_nettype none

module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[hex_i];

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// +---------------------------------------------------------------------------+
// | seg_scan_ctrl : multiplexed seven-segment scanner with guard-blanked     |
// | slots and frame-aligned value update. Optional macro: SEG_LZB_EN         |
// | (leading-zero blanking). Revision: 1.0                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int GUARD = 500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              pending,
    output logic              frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0] C_CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] C_GUARD   = CW'(GUARD);
    localparam logic [DW-1:0] C_DIG_MAX = DW'(NDIG - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [4*NDIG-1:0] act_val_q, act_val_d;
    logic [NDIG-1:0]   act_dp_q, act_dp_d;
    logic [4*NDIG-1:0] shd_val_q, shd_val_d;
    logic [NDIG-1:0]   shd_dp_q, shd_dp_d;
    logic              pending_q, pending_d;
    seg_state_e        state_q, state_d;

    logic [NDIG-1:0]   an_q;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic              ftick_q;

    logic              w_slot_end;
    logic              w_frame_end;
    logic [3:0]        w_nib;
    logic              w_dp_lit;
    logic [NDIG-1:0]   w_an_sel;
    logic [6:0]        w_seg;
    logic              w_lz_blank;

    assign w_slot_end  = (cnt_q == C_CNT_MAX);
    assign w_frame_end = w_slot_end && (dig_q == C_DIG_MAX);

    always_comb begin
        cnt_d     = w_slot_end ? '0 : cnt_q + 1'b1;
        dig_d     = dig_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        shd_val_d = shd_val_q;
        shd_dp_d  = shd_dp_q;
        pending_d = pending_q;

        if (w_slot_end) begin
            dig_d = (dig_q == C_DIG_MAX) ? '0 : dig_q + 1'b1;
        end

        if (w_frame_end) begin
            // A load landing on the boundary itself goes straight to active
            if (load) begin
                act_val_d = value;
                act_dp_d  = dp_in;
            end else if (pending_q) begin
                act_val_d = shd_val_q;
                act_dp_d  = shd_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shd_val_d = value;
            shd_dp_d  = dp_in;
            pending_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up with cnt
    always_comb begin
        w_nib    = 4'h0;
        w_dp_lit = 1'b0;
        w_an_sel = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_d == DW'(i)) begin
                w_nib       = act_val_d[4*i +: 4];
                w_dp_lit    = act_dp_d[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    hex7seg u_hex7seg (
        .hex_i (w_nib),
        .seg_o (w_seg)
    );

`ifdef SEG_LZB_EN
    logic [DW-1:0] w_msd;

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < NDIG; i++) begin
            if (act_val_d[4*i +: 4] != 4'h0) begin
                w_msd = DW'(i);
            end
        end
    end

    assign w_lz_blank = (dig_d > w_msd);
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_d == C_GUARD) state_d = DRIVE;
            DRIVE:   if (cnt_d == '0)      state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            dig_q     <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            shd_val_q <= '0;
            shd_dp_q  <= '0;
            pending_q <= 1'b0;
            state_q   <= BLANK;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            ftick_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            shd_val_q <= shd_val_d;
            shd_dp_q  <= shd_dp_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            ftick_q   <= w_frame_end;
            if (state_d == DRIVE) begin
                an_q  <= w_an_sel;
                seg_q <= w_lz_blank ? SEG_OFF : w_seg;
                dp_q  <= ~w_dp_lit;
            end else begin
                an_q  <= '1;
                seg_q <= SEG_OFF;
                dp_q  <= 1'b1;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign pending    = pending_q;
    assign frame_tick = ftick_q;

endmodule

`default_nettype wire
